// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: op codes,
// FSM states and the execute-stage don't-care operand pattern.
package muldiv_ctrl_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    // Fill pattern the execute stage drives on unused operand lanes.
    localparam logic [31:0] DC32 = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_FIX  = 2'd2
    } md_state_t;

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on the {upper, lower} accumulator: shift-add for
// multiply, trial-subtract/restore for divide (upper = remainder, lower = quotient).
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    input  logic               div_mode,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    always_comb begin
        sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
        shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        trial   = shifted - {1'b0, operand};
        if (!div_mode) begin
            acc_next = {sum, acc[WIDTH-1:1]};
        end else if (!trial[WIDTH]) begin
            acc_next = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            acc_next = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers.
//   state   | meaning
//   MD_IDLE | accepts start, MTHI/MTLO writes
//   MD_RUN  | one radix-2 step per cycle on operand magnitudes
//   MD_FIX  | sign correction, HI/LO write, done pulse
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEPS = WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(STEPS);

    md_state_t          state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   divisor;
    logic [WIDTH-1:0]   rs_keep;
    logic [WIDTH-1:0]   a_f, b_f, a_mag, b_mag, quo, rem;
    logic               a_neg, b_neg;
    logic               is_div, neg_q, neg_r, div0;

    always_comb begin
        a_f   = (rs_val == WIDTH'(DC32)) ? '0 : rs_val;
        b_f   = (rt_val == WIDTH'(DC32)) ? '0 : rt_val;
        a_neg = op_is_signed(op) && a_f[WIDTH-1];
        b_neg = op_is_signed(op) && b_f[WIDTH-1];
        a_mag = a_neg ? -a_f : a_f;
        b_mag = b_neg ? -b_f : b_f;
        prod  = neg_q ? -acc : acc;
        quo   = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem   = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc),
        .operand  (divisor),
        .div_mode (is_div),
        .acc_next (acc_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= MD_IDLE;
            cnt     <= '0;
            acc     <= '0;
            divisor <= '0;
            rs_keep <= '0;
            is_div  <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            div0    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                MD_IDLE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (start && !flush) begin
                        state   <= MD_RUN;
                        busy    <= 1'b1;
                        cnt     <= '0;
                        acc     <= {{WIDTH{1'b0}}, a_mag};
                        divisor <= b_mag;
                        rs_keep <= a_f;
                        is_div  <= op_is_div(op);
                        neg_q   <= a_neg ^ b_neg;
                        neg_r   <= a_neg;
                        div0    <= op_is_div(op) && (b_f == '0);
                    end
                end
                MD_RUN: begin
                    if (flush) begin
                        state <= MD_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        acc <= acc_next;
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(STEPS - 1)) state <= MD_FIX;
                    end
                end
                MD_FIX: begin
                    state <= MD_IDLE;
                    busy  <= 1'b0;
                    if (!flush) begin
                        done <= 1'b1;
                        // Divide by zero reports the raw dividend, unsigned all-ones quotient.
                        if (div0) begin
                            hi <= rs_keep;
                            lo <= '1;
                        end else if (is_div) begin
                            hi <= rem;
                            lo <= quo;
                        end else begin
                            hi <= prod[2*WIDTH-1:WIDTH];
                            lo <= prod[WIDTH-1:0];
                        end
                    end
                end
                default: begin
                    state <= MD_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Multi-cycle sequencer for MIPS MULT/MULTU/DIV/DIVU in the execute stage; owns the HI/LO architectural registers.
- Runs a radix-2 shift-add multiply or restoring divide, one step per cycle, and raises busy so the hazard unit stalls dependent MFHI/MFLO and any further mult/div.
- Also services MTHI/MTLO writes and provides HI/LO for reads.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- STEPS, WIDTH, iteration count; must equal WIDTH.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- start  in  1  request a mult/div; sampled only in IDLE
- op  in  2  operation select, see package constants
- rs_val  in  WIDTH  multiplicand / dividend
- rt_val  in  WIDTH  multiplier / divisor
- flush  in  1  pipeline flush; aborts an in-flight operation
- hi_we  in  1  MTHI write strobe
- lo_we  in  1  MTLO write strobe
- wdata  in  WIDTH  MTHI/MTLO data
- busy  out  1  high while state != IDLE
- done  out  1  one-cycle pulse; HI/LO updated this cycle
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset: state=IDLE, hi=0, lo=0, busy=0, done=0, step counter=0. Reset mid-operation abandons the operation. HI/LO return to 0.
- Operand filtering: at accept, an operand equal to `dc32 is treated as 0, matching execute-stage convention.
- FSM states and transitions:
  - IDLE: on start & !flush, go to RUN. Latch op and magnitudes of the operands (signed ops take the absolute value). Latch the result sign (mult: sign_a^sign_b; div: quotient sign_a^sign_b, remainder sign_a). Counter=0.
  - RUN: one iteration per cycle. After the iteration with counter==STEPS-1, go to FIX.
  - FIX: apply two's-complement sign correction to the 2*WIDTH product, or to the quotient and remainder separately. Write hi/lo, pulse done, return to IDLE.
- Latency: accept edge E. RUN occupies edges E+1..E+32, FIX is at edge E+33. hi/lo/done are valid in the cycle after edge E+33. busy is high in the cycles after E through E+33.
- Result mapping:
  - Multiply: {hi,lo} = 64-bit product.
  - Divide: lo = quotient, hi = remainder.
- Divide by zero: runs the full latency. Result is forced to lo=32'hFFFFFFFF and hi=filtered rs_val, with no sign correction.
- start while busy: ignored, with no queueing. The hazard unit must not issue.
- flush while busy: go to IDLE next edge. hi/lo keep their pre-operation values. No done.
- flush with start in IDLE: start is ignored.
- MTHI/MTLO:
  - In IDLE, hi_we/lo_we write wdata at the edge. Both strobes may be set in the same cycle.
  - While busy, the writes are ignored.
  - start together with hi_we/lo_we in IDLE: the write happens this edge, then the operation's result overwrites it at FIX.
- Overflow: none, since results are full-width by construction.

Decomposition:
- Shared header mips.h gains:
  - `MD_mult=2'b00, `MD_multu=2'b01, `MD_div=2'b10, `MD_divu=2'b11
  - state encodings `MD_IDLE, `MD_RUN, `MD_FIX
- Sub-module muldiv_step: a combinational single iteration. It takes the accumulator, the operand and a mode bit, and returns the next accumulator (shift-add for mult, trial-subtract/restore for div). muldiv_ctrl holds the FSM, counter, sign logic and HI/LO registers.

Test Plan:
- MULT rs=7, rt=6: start at edge E -> busy through edge E+33; done pulse after E+33; hi=0, lo=42.
- MULT rs=-3, rt=5 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFF1. MULTU rs=32'hFFFFFFFF, rt=2 -> hi=1, lo=32'hFFFFFFFE.
- DIVU 100/7 -> lo=14, hi=2. DIV -7/2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF. DIVU 5/0 -> lo=32'hFFFFFFFF, hi=5.
- Preload via MTHI=32'hA5A5A5A5, then start MULT 2*3 and assert flush at RUN cycle 10 -> busy drops next cycle; no done; hi=32'hA5A5A5A5, lo unchanged.
- During busy, pulse start with a new op and pulse hi_we -> both ignored; result is that of the first op only.
- Assert reset mid-RUN -> next cycle busy=0, done=0, hi=lo=0. A new start afterwards completes with normal latency.
